// File: rtl/led_mux_scan.sv
// N-channel selector with manual, auto-scan, button-step and hold modes.
// Drives the registered selected channel and a one-hot LED bar showing it.
module led_mux_scan #(
  parameter int NCH   = 8,
  parameter int DW    = 1,
  parameter int DIV   = 5000000,
  parameter int LED_W = 16,
  localparam int SW   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [SW-1:0]     sel_in,
  input  logic [NCH*DW-1:0] data_in,
  input  logic              step,
  output logic [DW-1:0]     dout,
  output logic [SW-1:0]     cur_sel,
  output logic [LED_W-1:0]  ledr
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e         mode_p0;
  logic [DW-1:0] chan_p0 [NCH];
  logic [SW-1:0] sel_p1, sel_nxt;
  logic [CW-1:0] cnt_p1, cnt_nxt;
  logic [DW-1:0] dout_p1, dout_nxt;
  logic          step_s1, step_s2, step_s3;
  logic          step_edge;
  logic [NCH-1:0] onehot;

  assign mode_p0 = mode_e'(mode);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan_p0[k] = data_in[k*DW +: DW];
  end

  // Stage 0: button synchroniser runs in every mode so STEP entry sees no stale edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign step_edge = step_s2 & ~step_s3;

  always_comb begin
    sel_nxt  = sel_p1;
    cnt_nxt  = cnt_p1;
    dout_nxt = chan_p0[sel_p1];
    unique case (mode_p0)
      MODE_MANUAL: begin
        sel_nxt = sel_in;
        cnt_nxt = '0;
      end
      MODE_AUTO: begin
        if (cnt_p1 == CW'(DIV - 1)) begin
          cnt_nxt = '0;
          sel_nxt = sel_p1 + SW'(1);
        end else begin
          cnt_nxt = cnt_p1 + CW'(1);
        end
      end
      MODE_STEP: begin
        if (step_edge) sel_nxt = sel_p1 + SW'(1);
        cnt_nxt = '0;
      end
      MODE_HOLD: begin
        dout_nxt = dout_p1;
      end
      default: ;
    endcase
  end

  // Stage 1: select, dwell counter and selected data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_p1  <= '0;
      cnt_p1  <= '0;
      dout_p1 <= '0;
    end else begin
      sel_p1  <= sel_nxt;
      cnt_p1  <= cnt_nxt;
      dout_p1 <= dout_nxt;
    end
  end

  assign onehot  = {{(NCH-1){1'b0}}, 1'b1} << sel_p1;
  assign dout    = dout_p1;
  assign cur_sel = sel_p1;

  always_comb begin
    ledr                  = '0;
    ledr[NCH-1:0]         = onehot;
    ledr[LED_W-1 -: DW]   = dout_p1;
  end

endmodule
